serial_adder_ctrl: RTL and testbench

Bit-serial N-bit adder controller. It sequences a single instance of the team's structural full-adder cell S_fulladder (ports a, b, cin, sum, cout) over WIDTH clock cycles, LSB first. It holds the carry between bits in a flip-flop and presents a registered WIDTH-bit result with a start/busy/done handshake. It is the area-minimal alternative to the ripple-carry adder in the structural modelling library.

---
 rtl/serial_adder_ctrl.sv | 80 ++++++++
 tb/tb_serial_adder_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencing one full-adder cell LSB first
module S_fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nx;
    logic [CNT_W-1:0] cnt;
    logic carry_q, fa_sum, fa_cout, load, last;

    S_fulladder u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry_q), .sum(fa_sum), .cout(fa_cout));

    // the newest sum bit enters at the MSB so bit 0 lands at s_sr[0] after WIDTH shifts
    assign s_nx = WIDTH'({fa_sum, s_sr} >> 1);
    assign busy = state == RUN;
    assign done = state == FIN;

    always_comb begin
        load     = start && state != RUN;
        last     = state == RUN && cnt == CNT_W'(WIDTH - 1);
        state_nx = load ? RUN : (state == RUN ? (last ? FIN : RUN) : IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            if (load) begin
                a_sr    <= a;
                b_sr    <= b;
                carry_q <= cin;
                cnt     <= '0;
            end else if (state == RUN) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                s_sr    <= s_nx;
                carry_q <= fa_cout;
                cnt     <= cnt + CNT_W'(1);
            end
            if (last) begin
                sum  <= s_nx;
                cout <= fa_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed scoreboard bench for 8-bit and 3-bit serial adders
module tb_serial_adder_ctrl;
    typedef struct {
        int          cyc;
        logic [63:0] val;
    } exp_t;

    logic clk = 0, rst_n = 1;
    logic start8 = 0, cin8 = 0, busy8, done8, cout8;
    logic [7:0] a8 = 0, b8 = 0, sum8;
    logic start3 = 0, cin3 = 0, busy3, done3, cout3;
    logic [2:0] a3 = 0, b3 = 0, sum3;
    int cyc = 0, n_vec = 0, n_err = 0;
    exp_t q8[$], q3[$];

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder_ctrl #(.WIDTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // done is visible after edge E0+WIDTH; the accepting edge is the one after this negedge
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) check("unexpected_done8", 1, 0);
            else begin
                e = q8.pop_front();
                check("result8", {55'd0, cout8, sum8}, e.val);
                check("latency8", cyc, e.cyc);
                check("busy_in_fin8", busy8, 0);
            end
        end
        if (done3) begin
            if (q3.size() == 0) check("unexpected_done3", 1, 0);
            else begin
                e = q3.pop_front();
                check("result3", {60'd0, cout3, sum3}, e.val);
                check("latency3", cyc, e.cyc);
                check("busy_in_fin3", busy3, 0);
            end
        end
    end

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] exp);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1;
        q8.push_back('{cyc + 9, {55'd0, exp}});
        @(negedge clk);
        start8 = 0; a8 = ~a; b8 = ~b; cin8 = ~c;
        repeat (8) @(negedge clk);
    endtask

    task automatic go3(input logic [2:0] a, input logic [2:0] b, input logic c);
        @(negedge clk);
        a3 = a; b3 = b; cin3 = c; start3 = 1;
        q3.push_back('{cyc + 4, 64'(a) + 64'(b) + 64'(c)});
        @(negedge clk);
        start3 = 0; a3 = ~a; b3 = ~b;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        check("reset_out8", {busy8, done8, cout8, sum8}, 0);
        check("reset_out3", {busy3, done3, cout3, sum3}, 0);
        rst_n = 1;
        // single addition with busy profile
        @(negedge clk);
        a8 = 0; b8 = 0; cin8 = 0; start8 = 1;
        q8.push_back('{cyc + 9, 64'h000});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start8 = 0;
            check("busy_run", {busy8, done8}, 2'b10);
        end
        @(negedge clk);
        go8(8'hFF, 8'h01, 0, 9'h100);
        go8(8'hA5, 8'h5A, 1, 9'h100);
        go8(8'h3C, 8'h42, 0, 9'h07E);
        // start held high: back-to-back additions at WIDTH+1 spacing
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1;
        for (int k = 0; k < 3; k++) begin
            q8.push_back('{cyc + 9, 64'h030});
            if (k < 2) repeat (9) @(negedge clk);
        end
        @(negedge clk);
        start8 = 0;
        repeat (8) @(negedge clk);
        // starts during RUN are ignored
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 0; start8 = 1;
        q8.push_back('{cyc + 9, 64'h002});
        @(negedge clk);
        start8 = 0;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1;
        repeat (4) @(negedge clk);
        start8 = 0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("idle_after_ignore", {busy8, done8}, 0);
        @(negedge clk);
        check("still_idle", {busy8, done8}, 0);
        // asynchronous abort mid-RUN
        a8 = 8'h7F; b8 = 8'h01; cin8 = 0; start8 = 1;
        @(negedge clk);
        start8 = 0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", busy8, 1);
        rst_n = 0;
        #1 check("abort_clears", {busy8, done8, cout8, sum8}, 0);
        @(negedge clk);
        check("abort_held", {busy8, done8, cout8, sum8}, 0);
        rst_n = 1;
        go8(8'h7F, 8'h01, 0, 9'h080);
        // exhaustive 3-bit
        for (int v = 0; v < 128; v++) go3(3'(v), 3'(v >> 3), v[6]);
        for (int i = 0; i < 20 && (q8.size() != 0 || q3.size() != 0); i++) @(negedge clk);
        check("drain8", q8.size(), 0);
        check("drain3", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
